simplebus_target: RTL
=====================

# simplebus_target

Synthesizable, parametrised target for the Microwatt external simple bus: decodes read/write commands arriving byte-serially on an 8-bit parity-protected bus, services them from an internal byte-maskable word memory, and returns acks and read data on a separate 8-bit output bus. It replaces behavioural bus-model responders. It can sit on the GPIO-facing side of a bridge or in an FPGA companion device. Unlike a fixed model, it is sized by parameter and reports protocol faults instead of halting.

## Interface
- ADDR_BYTES, 4, address bytes per command (1..4)
- DATA_BYTES, 8, data bytes per word; power of two, 1..8
- READ_DELAY, 8, cycles from last read-address byte to read ack (1..15)
- MEM_WORDS_LOG2, 6, log2 of memory depth in words
- clk  in  1  bus clock; all logic on rising edge
- resetb  in  1  synchronous, active-low reset
- bus_in  in  8  command/address/sel/data byte from master
- bus_pty_in  in  1  odd parity for bus_in: must equal ~^bus_in
- bus_out  out  8  ack/data byte to master; 0x00 when idle
- bus_pty_out  out  1  ~^bus_out
- clear_flags  in  1  one-cycle pulse that clears parity_err and overrun
- busy  out  1  high whenever the RX FSM is not IDLE or TX bytes remain
- parity_err  out  1  sticky; set on any received parity mismatch
- overrun  out  1  sticky; set on a command byte received while TX busy

## Operation
- Commands: 0x02 READ, 0x03 WRITE. Acks: 0x82 READ_ACK, 0x83 WRITE_ACK, 0xFE NAK.
- All multi-byte fields are sent LSB byte first.
- RX FSM states: IDLE, WR_ADDR, WR_SEL, WR_DATA, RD_ADDR, RD_DELAY.
- IDLE: 0x03 -> WR_ADDR. 0x02 -> RD_ADDR. The address counter loads ADDR_BYTES. Any other byte is ignored.
- WR_ADDR / RD_ADDR: shift the byte into addr. After ADDR_BYTES bytes: write -> WR_SEL; read -> RD_DELAY with counter = READ_DELAY.
- WR_SEL: latch sel[DATA_BYTES-1:0]; upper bits are ignored. Next state WR_DATA with DATA_BYTES count.
- WR_DATA: shift data. On the last byte, commit and queue the ack, then -> IDLE.
- Commit for a valid address: for each i with sel[i]=1, write byte lane i, then queue 0x83. sel=0 performs no write and still returns 0x83.
- A valid address is aligned to DATA_BYTES (low log2(DATA_BYTES) bits zero) with word index < 2^MEM_WORDS_LOG2; all higher addr bits must be zero.
- Invalid address: nothing is written, and the queued response is NAK only.
- RD_DELAY: memory is read on the first delay cycle. When the counter expires, queue 0x82 then the DATA_BYTES word, LSB first, and -> IDLE. An invalid address queues NAK only.
- TX: a shift register of up to 1+DATA_BYTES bytes and a byte count. It drives one byte per cycle, then 0x00.
- Parity mismatch on any cycle sets parity_err.
- Parity mismatch while RX is not IDLE also aborts the command: no memory write, NAK queued, RX -> IDLE.
- A command byte (0x02/0x03) seen in IDLE while TX is still busy is dropped, RX stays IDLE, and overrun is set.
- If clear_flags coincides with a new error, the set wins.
- Memory contents are not reset.

## Timing
- Reset values: bus_out=0x00, bus_pty_out=1, busy=0, parity_err=0, overrun=0, RX=IDLE, TX count=0.
- Reset mid-command or mid-response: the response is dropped and bus_out returns to 0x00 on the next edge. Memory keeps all completed writes.
- Edge numbering: edge 0 samples the command byte.
- Write:
  - Edges 1..A sample the address.
  - Edge A+1 samples sel.
  - Edges A+2..A+1+D sample the data.
  - bus_out=0x83 from edge A+2+D for one cycle.
- Read: the last address is sampled at edge A. bus_out=0x82 from edge A+READ_DELAY+1, followed by data byte k at edge A+READ_DELAY+2+k.
- A read issued on the cycle after a write ack sees the written data.
- busy rises on the edge after the command byte is sampled. It falls on the edge where bus_out returns to 0x00.
- Flags update one edge after the offending byte is sampled.

## Test plan
- Reset, idle bus for 10 cycles -> bus_out=0x00, bus_pty_out=1, all flags 0.
- WRITE addr 0x00000010, sel 0xFF, data 0x0102030405060708, then READ 0x10 -> 0x83 at edge 14; read returns 0x82 at edge A+9, then 08,07,…,01.
- WRITE 0x10 sel 0x0F data 0xAAAA…AA, then READ 0x10 -> data 0x01020304AAAAAAAA (LSB first: AA,AA,AA,AA,04,03,02,01).
- READ 0x0000000C (misaligned) and READ 0x00001000 (out of range) -> single 0xFE each, no data bytes.
- Flip bus_pty_in on the third address byte of a WRITE -> parity_err=1, NAK, and a follow-up read shows memory unchanged; then pulse clear_flags -> parity_err=0.
- Issue READ, then send 0x03 while the read response is transmitting -> overrun=1 and the response completes intact. Assert resetb=0 mid-response -> bus_out=0x00 next edge.

Source files
------------

// File: rtl/simplebus_if.sv
// Byte-serial Microwatt simple-bus signal bundle.
// The master drives commands and parity; the slave (target) returns acks, data and status flags.
interface simplebus_if;
    logic [7:0] bus_in;
    logic       bus_pty_in;
    logic [7:0] bus_out;
    logic       bus_pty_out;
    logic       clear_flags;
    logic       busy;
    logic       parity_err;
    logic       overrun;

    modport master (
        output bus_in, bus_pty_in, clear_flags,
        input  bus_out, bus_pty_out, busy, parity_err, overrun
    );

    modport slave (
        input  bus_in, bus_pty_in, clear_flags,
        output bus_out, bus_pty_out, busy, parity_err, overrun
    );
endinterface

// File: rtl/simplebus_target.sv
// Simple-bus target: decodes byte-serial READ/WRITE commands and services them from a
// byte-maskable word memory. Responses leave through a TX shift register one byte per
// cycle. Parity faults abort a command with a NAK. Command bytes that arrive while a
// response is still draining are dropped and flagged as overrun.
module simplebus_target #(
    parameter int ADDR_BYTES     = 4,
    parameter int DATA_BYTES     = 8,
    parameter int READ_DELAY     = 8,
    parameter int MEM_WORDS_LOG2 = 6
) (
    input  logic        clk,
    input  logic        resetb,
    simplebus_if.slave  bus
);
    localparam int AW        = 8 * ADDR_BYTES;
    localparam int DW        = 8 * DATA_BYTES;
    localparam int TXW       = DW + 8;
    localparam int LANE_LOG2 = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 0;
    localparam int DEPTH     = 1 << MEM_WORDS_LOG2;

    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;
    localparam logic [7:0] ACK_READ  = 8'h82;
    localparam logic [7:0] ACK_WRITE = 8'h83;
    localparam logic [7:0] NAK       = 8'hFE;

    localparam logic [3:0] ADDR_CNT  = 4'(ADDR_BYTES);
    localparam logic [3:0] DATA_CNT  = 4'(DATA_BYTES);
    localparam logic [3:0] DELAY_CNT = 4'(READ_DELAY);
    localparam logic [3:0] RESP_CNT  = 4'(DATA_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_SEL,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_DELAY
    } state_t;

    // Control state (reset)
    state_t               r_state, w_state_nx;
    logic [3:0]           r_cnt, w_cnt_nx;
    logic [3:0]           r_tx_cnt, w_tx_cnt_nx;
    logic                 r_perr, w_perr_nx;
    logic                 r_ovr, w_ovr_nx;

    // Datapath state (not reset)
    logic [AW-1:0]        r_addr, w_addr_nx;
    logic [DATA_BYTES-1:0] r_sel, w_sel_nx;
    logic [DW-1:0]        r_data, w_data_nx;
    logic [TXW-1:0]       r_tx_sr, w_tx_sr_nx;
    logic [DW-1:0]        r_rd_data;
    logic [DW-1:0]        r_mem [DEPTH];

    logic                      w_pty_bad;
    logic [AW-1:0]             w_addr_sh;
    logic [DW-1:0]             w_data_sh;
    logic [MEM_WORDS_LOG2-1:0] w_idx;
    logic                      w_addr_ok;
    logic [DW-1:0]             w_rd_word;
    logic                      w_rd_latch;
    logic                      w_mem_we;
    logic [7:0]                w_bus_out;

    // An address is usable only if it is lane-aligned and has no bits above the word index.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < AW; i++) begin
            if (a[i] && (i < LANE_LOG2 || i >= LANE_LOG2 + MEM_WORDS_LOG2)) ok = 1'b0;
        end
        return ok;
    endfunction

    assign w_pty_bad = (bus.bus_pty_in != ~^bus.bus_in);
    // Fields arrive LSB byte first, so each new byte enters at the top and moves down.
    assign w_addr_sh = (r_addr >> 8) | (AW'(bus.bus_in) << (AW - 8));
    assign w_data_sh = (r_data >> 8) | (DW'(bus.bus_in) << (DW - 8));
    assign w_idx     = MEM_WORDS_LOG2'(r_addr >> LANE_LOG2);
    assign w_addr_ok = addr_ok(r_addr);
    // The word is captured on the first delay cycle. When the delay is a single cycle,
    // that capture and the response load fall on the same edge, so the memory is used directly.
    assign w_rd_word = (r_cnt == DELAY_CNT) ? r_mem[w_idx] : r_rd_data;

    assign w_bus_out       = (r_tx_cnt != 4'd0) ? r_tx_sr[7:0] : 8'h00;
    assign bus.bus_out     = w_bus_out;
    assign bus.bus_pty_out = ~^w_bus_out;
    assign bus.busy        = (r_state != S_IDLE) || (r_tx_cnt != 4'd0);
    assign bus.parity_err  = r_perr;
    assign bus.overrun     = r_ovr;

    // RX command decoder, TX drain, and sticky flag logic
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_addr_nx   = r_addr;
        w_sel_nx    = r_sel;
        w_data_nx   = r_data;
        w_tx_sr_nx  = r_tx_sr;
        w_tx_cnt_nx = r_tx_cnt;
        w_perr_nx   = r_perr;
        w_ovr_nx    = r_ovr;
        w_rd_latch  = 1'b0;
        w_mem_we    = 1'b0;

        if (r_tx_cnt != 4'd0) begin
            w_tx_sr_nx  = r_tx_sr >> 8;
            w_tx_cnt_nx = r_tx_cnt - 4'd1;
        end

        // Clear first so that a coincident new error still sets its flag.
        if (bus.clear_flags) begin
            w_perr_nx = 1'b0;
            w_ovr_nx  = 1'b0;
        end
        if (w_pty_bad) w_perr_nx = 1'b1;

        if (w_pty_bad && r_state != S_IDLE) begin
            w_state_nx  = S_IDLE;
            w_tx_sr_nx  = TXW'(NAK);
            w_tx_cnt_nx = 4'd1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_pty_bad && (bus.bus_in == CMD_READ || bus.bus_in == CMD_WRITE)) begin
                        if (r_tx_cnt != 4'd0) begin
                            w_ovr_nx = 1'b1;
                        end else begin
                            w_state_nx = (bus.bus_in == CMD_WRITE) ? S_WR_ADDR : S_RD_ADDR;
                            w_cnt_nx   = ADDR_CNT;
                        end
                    end
                end
                S_WR_ADDR, S_RD_ADDR: begin
                    w_addr_nx = w_addr_sh;
                    w_cnt_nx  = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (r_state == S_WR_ADDR) begin
                            w_state_nx = S_WR_SEL;
                        end else begin
                            w_state_nx = S_RD_DELAY;
                            w_cnt_nx   = DELAY_CNT;
                        end
                    end
                end
                S_WR_SEL: begin
                    w_sel_nx   = bus.bus_in[DATA_BYTES-1:0];
                    w_state_nx = S_WR_DATA;
                    w_cnt_nx   = DATA_CNT;
                end
                S_WR_DATA: begin
                    w_data_nx = w_data_sh;
                    w_cnt_nx  = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nx  = S_IDLE;
                        w_tx_cnt_nx = 4'd1;
                        if (w_addr_ok) begin
                            w_mem_we   = 1'b1;
                            w_tx_sr_nx = TXW'(ACK_WRITE);
                        end else begin
                            w_tx_sr_nx = TXW'(NAK);
                        end
                    end
                end
                S_RD_DELAY: begin
                    w_rd_latch = (r_cnt == DELAY_CNT);
                    w_cnt_nx   = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nx = S_IDLE;
                        if (w_addr_ok) begin
                            w_tx_sr_nx  = {w_rd_word, ACK_READ};
                            w_tx_cnt_nx = RESP_CNT;
                        end else begin
                            w_tx_sr_nx  = TXW'(NAK);
                            w_tx_cnt_nx = 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_tx_cnt <= 4'd0;
            r_perr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_tx_cnt <= w_tx_cnt_nx;
            r_perr   <= w_perr_nx;
            r_ovr    <= w_ovr_nx;
        end
    end

    // Datapath registers; their contents only matter while control qualifies them
    always_ff @(posedge clk) begin
        r_addr  <= w_addr_nx;
        r_sel   <= w_sel_nx;
        r_data  <= w_data_nx;
        r_tx_sr <= w_tx_sr_nx;
        if (w_rd_latch) r_rd_data <= r_mem[w_idx];
    end

    // Byte-lane memory write; a write that lands on a reset edge is abandoned
    always_ff @(posedge clk) begin
        if (resetb && w_mem_we) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (r_sel[i]) r_mem[w_idx][8*i +: 8] <= w_data_sh[8*i +: 8];
            end
        end
    end
endmodule
